// File: rtl/ball_motion_engine.sv
// rtl/ball_motion_engine.sv - multi-ball motion engine with shared update datapath and double-buffered outputs
module ball_motion_engine #(
    parameter int BALL_NUM = 3,
    parameter int X_W      = 10,
    parameter int Y_W      = 10,
    parameter int SCREEN_W = 640,
    parameter int SCREEN_H = 480,
    parameter int RADIUS   = 4,
    parameter int SPEED    = 2
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    enable,
    input  logic                    frame_tick,
    input  logic                    launch,
    input  logic [X_W-1:0]          paddle_x,
    input  logic [Y_W-1:0]          paddle_y,
    input  logic [7:0]              paddle_len,
    output logic [BALL_NUM*X_W-1:0] b_xs,
    output logic [BALL_NUM*Y_W-1:0] b_ys,
    output logic [BALL_NUM-1:0]     b_active,
    output logic                    busy,
    output logic                    miss,
    output logic                    hit_paddle,
    output logic                    overrun
);

    localparam int IDX_W = (BALL_NUM > 1) ? $clog2(BALL_NUM) : 1;
    localparam int SX_W  = X_W + 2;
    localparam int SY_W  = Y_W + 2;

    localparam logic signed [SX_W-1:0] X_LO  = SX_W'(RADIUS);
    localparam logic signed [SX_W-1:0] X_HI  = SX_W'(SCREEN_W - 1 - RADIUS);
    localparam logic signed [SY_W-1:0] Y_LO  = SY_W'(RADIUS);
    localparam logic signed [SY_W-1:0] Y_HI  = SY_W'(SCREEN_H - 1 - RADIUS);
    localparam logic signed [SY_W-1:0] Y_RAD = SY_W'(RADIUS);
    localparam logic signed [SY_W-1:0] Y_ONE = SY_W'(1);
    localparam logic signed [3:0]      V_SPEED   = 4'(SPEED);
    localparam logic signed [3:0]      LAUNCH_DY = -V_SPEED;

    typedef enum logic [2:0] {
        S_IDLE,
        S_CALC,
        S_WRITE,
        S_COMMIT,
        S_LAUNCH
    } state_t;

    state_t state;
    logic [IDX_W-1:0] idx;

    // Shadow copy of every ball; the committed outputs only change at COMMIT or LAUNCH
    logic [X_W-1:0]      sh_x [BALL_NUM];
    logic [Y_W-1:0]      sh_y [BALL_NUM];
    logic signed [3:0]   vx   [BALL_NUM];
    logic signed [3:0]   vy   [BALL_NUM];
    logic [BALL_NUM-1:0] sh_act;

    logic launch_pend;
    logic miss_acc;
    logic hit_acc;

    logic signed [SX_W-1:0] calc_x;
    logic signed [SY_W-1:0] calc_y;

    logic [X_W-1:0]    cur_x;
    logic [Y_W-1:0]    cur_y;
    logic signed [3:0] cur_dx;
    logic signed [3:0] cur_dy;

    logic signed [SX_W-1:0] px_ext;
    logic signed [SX_W-1:0] len_ext;
    logic signed [SY_W-1:0] py_ext;
    logic signed [SY_W-1:0] y_ext;

    logic signed [SX_W-1:0] wr_x;
    logic signed [SY_W-1:0] wr_y;
    logic signed [3:0]      wr_dx;
    logic signed [3:0]      wr_dy;
    logic                   wr_act;
    logic                   wr_hit;
    logic                   wr_miss;

    logic             free_any;
    logic [IDX_W-1:0] free_idx;
    logic [X_W-1:0]   launch_x;
    logic [Y_W-1:0]   launch_y;
    logic signed [3:0] launch_dx;

    // Select the ball currently owned by the shared datapath and widen operands to signed
    always_comb begin
        cur_x   = sh_x[idx];
        cur_y   = sh_y[idx];
        cur_dx  = vx[idx];
        cur_dy  = vy[idx];
        px_ext  = $signed({2'b00, paddle_x});
        len_ext = $signed(SX_W'(paddle_len));
        py_ext  = $signed({2'b00, paddle_y});
        y_ext   = $signed({2'b00, cur_y});
    end

    // Collision rules applied in order to the candidate position computed in CALC
    always_comb begin
        wr_x    = calc_x;
        wr_y    = calc_y;
        wr_dx   = cur_dx;
        wr_dy   = cur_dy;
        wr_act  = 1'b1;
        wr_hit  = 1'b0;
        wr_miss = 1'b0;
        if (wr_x < X_LO) begin
            wr_x  = X_LO;
            wr_dx = -wr_dx;
        end else if (wr_x > X_HI) begin
            wr_x  = X_HI;
            wr_dx = -wr_dx;
        end
        if (wr_y < Y_LO) begin
            wr_y  = Y_LO;
            wr_dy = -wr_dy;
        end
        if ((wr_dy > 4'sd0) && (y_ext + Y_RAD < py_ext) && (wr_y + Y_RAD >= py_ext) &&
            (px_ext <= wr_x) && (wr_x <= px_ext + len_ext)) begin
            wr_y   = py_ext - Y_RAD - Y_ONE;
            wr_dy  = -wr_dy;
            wr_hit = 1'b1;
        end
        if (wr_y > Y_HI) begin
            wr_act  = 1'b0;
            wr_dx   = 4'sd0;
            wr_dy   = 4'sd0;
            wr_miss = 1'b1;
        end
    end

    // Lowest-index free ball and its launch position/velocity
    always_comb begin
        free_any = 1'b0;
        free_idx = '0;
        for (int k = BALL_NUM - 1; k >= 0; k--) begin
            if (!sh_act[k]) begin
                free_any = 1'b1;
                free_idx = IDX_W'(k);
            end
        end
        launch_x  = paddle_x + (X_W'(paddle_len) >> 1);
        launch_y  = paddle_y - Y_W'(RADIUS + 1);
        launch_dx = free_idx[0] ? -4'sd1 : 4'sd1;
    end

    // Sweep FSM, shared datapath registers, commit and launch handling
    always_ff @(posedge clock) begin
        if (!reset) begin
            state       <= S_IDLE;
            idx         <= '0;
            busy        <= 1'b0;
            miss        <= 1'b0;
            hit_paddle  <= 1'b0;
            overrun     <= 1'b0;
            launch_pend <= 1'b0;
            miss_acc    <= 1'b0;
            hit_acc     <= 1'b0;
            calc_x      <= '0;
            calc_y      <= '0;
            b_xs        <= '0;
            b_ys        <= '0;
            b_active    <= '0;
            sh_act      <= '0;
            for (int k = 0; k < BALL_NUM; k++) begin
                sh_x[k] <= '0;
                sh_y[k] <= '0;
                vx[k]   <= '0;
                vy[k]   <= '0;
            end
        end else if (enable) begin
            miss       <= 1'b0;
            hit_paddle <= 1'b0;
            if (frame_tick && busy) begin
                overrun <= 1'b1;
            end
            case (state)
                S_IDLE: begin
                    if (frame_tick) begin
                        idx      <= '0;
                        busy     <= 1'b1;
                        miss_acc <= 1'b0;
                        hit_acc  <= 1'b0;
                        state    <= S_CALC;
                    end else if (launch_pend && free_any) begin
                        state <= S_LAUNCH;
                    end
                end
                S_LAUNCH: begin
                    sh_x[free_idx]              <= launch_x;
                    sh_y[free_idx]              <= launch_y;
                    vx[free_idx]                <= launch_dx;
                    vy[free_idx]                <= LAUNCH_DY;
                    sh_act[free_idx]            <= 1'b1;
                    b_xs[free_idx*X_W +: X_W]   <= launch_x;
                    b_ys[free_idx*Y_W +: Y_W]   <= launch_y;
                    b_active[free_idx]          <= 1'b1;
                    launch_pend                 <= 1'b0;
                    if (frame_tick) begin
                        idx      <= '0;
                        busy     <= 1'b1;
                        miss_acc <= 1'b0;
                        hit_acc  <= 1'b0;
                        state    <= S_CALC;
                    end else begin
                        state <= S_IDLE;
                    end
                end
                S_CALC: begin
                    calc_x <= $signed({2'b00, cur_x}) + SX_W'(cur_dx);
                    calc_y <= $signed({2'b00, cur_y}) + SY_W'(cur_dy);
                    state  <= S_WRITE;
                end
                S_WRITE: begin
                    if (sh_act[idx]) begin
                        sh_x[idx]   <= wr_x[X_W-1:0];
                        sh_y[idx]   <= wr_y[Y_W-1:0];
                        vx[idx]     <= wr_dx;
                        vy[idx]     <= wr_dy;
                        sh_act[idx] <= wr_act;
                        miss_acc    <= miss_acc | wr_miss;
                        hit_acc     <= hit_acc | wr_hit;
                    end
                    if (idx == IDX_W'(BALL_NUM - 1)) begin
                        state <= S_COMMIT;
                    end else begin
                        idx   <= idx + 1'b1;
                        state <= S_CALC;
                    end
                end
                S_COMMIT: begin
                    for (int k = 0; k < BALL_NUM; k++) begin
                        b_xs[k*X_W +: X_W] <= sh_x[k];
                        b_ys[k*Y_W +: Y_W] <= sh_y[k];
                    end
                    b_active   <= sh_act;
                    miss       <= miss_acc;
                    hit_paddle <= hit_acc;
                    busy       <= 1'b0;
                    state      <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
            if (launch) begin
                launch_pend <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_ball_motion_engine.sv
// tb/tb_ball_motion_engine.sv - self-checking bench for ball_motion_engine
module tb_ball_motion_engine;

    localparam int N   = 3;
    localparam int X_W = 10;
    localparam int Y_W = 10;

    logic             clock = 1'b0;
    logic             reset = 1'b0;
    logic             enable = 1'b0;
    logic             frame_tick = 1'b0;
    logic             launch = 1'b0;
    logic [X_W-1:0]   paddle_x = '0;
    logic [Y_W-1:0]   paddle_y = '0;
    logic [7:0]       paddle_len = '0;
    logic [N*X_W-1:0] b_xs;
    logic [N*Y_W-1:0] b_ys;
    logic [N-1:0]     b_active;
    logic             busy;
    logic             miss;
    logic             hit_paddle;
    logic             overrun;

    ball_motion_engine #(
        .BALL_NUM(N), .X_W(X_W), .Y_W(Y_W), .SCREEN_W(640), .SCREEN_H(480), .RADIUS(4), .SPEED(2)
    ) dut (
        .clock(clock), .reset(reset), .enable(enable), .frame_tick(frame_tick), .launch(launch),
        .paddle_x(paddle_x), .paddle_y(paddle_y), .paddle_len(paddle_len),
        .b_xs(b_xs), .b_ys(b_ys), .b_active(b_active), .busy(busy),
        .miss(miss), .hit_paddle(hit_paddle), .overrun(overrun)
    );

    always #5 clock = ~clock;

    int n_cmp = 0;
    int n_bad = 0;
    bit rand_en = 1'b0;

    // Reference model: ball state as plain integers
    int mx [N];
    int my [N];
    int mdx[N];
    int mdy[N];
    bit mact[N];
    bit mpend;
    bit mmiss;
    bit mhit;

    typedef struct {
        int px; int py; int len;
        int l_x; int l_y;
        int f_x; int f_y;
    } vec_t;

    task automatic chk(input string name, input longint act, input longint exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic cycle(output bit was_en);
        enable = rand_en ? ($urandom_range(3) != 0) : 1'b1;
        was_en = enable;
        @(posedge clock);
        #1;
    endtask

    task automatic en_cycles(input int n);
        bit e;
        int got = 0;
        while (got < n) begin
            cycle(e);
            if (e) got++;
        end
    endtask

    task automatic model_clear();
        for (int k = 0; k < N; k++) begin
            mx[k] = 0; my[k] = 0; mdx[k] = 0; mdy[k] = 0; mact[k] = 0;
        end
        mpend = 0; mmiss = 0; mhit = 0;
    endtask

    task automatic do_reset();
        reset = 1'b0;
        enable = 1'b0;
        @(posedge clock); #1;
        @(posedge clock); #1;
        reset = 1'b1;
        model_clear();
    endtask

    task automatic model_frame();
        int nx, ny, dx, dy, px, py, len;
        px = paddle_x; py = paddle_y; len = paddle_len;
        mmiss = 0; mhit = 0;
        for (int k = 0; k < N; k++) begin
            if (mact[k]) begin
                nx = mx[k] + mdx[k]; ny = my[k] + mdy[k]; dx = mdx[k]; dy = mdy[k];
                if (nx < 4) begin nx = 4; dx = -dx; end
                else if (nx > 635) begin nx = 635; dx = -dx; end
                if (ny < 4) begin ny = 4; dy = -dy; end
                if (dy > 0 && my[k] + 4 < py && ny + 4 >= py && px <= nx && nx <= px + len) begin
                    ny = py - 5; dy = -dy; mhit = 1;
                end
                if (ny > 475) begin mact[k] = 0; dx = 0; dy = 0; mmiss = 1; end
                mx[k] = nx & 1023; my[k] = ny & 1023; mdx[k] = dx; mdy[k] = dy;
            end
        end
    endtask

    task automatic resolve_pend();
        if (mpend) begin
            for (int k = 0; k < N; k++) begin
                if (mpend && !mact[k]) begin
                    mx[k] = (int'(paddle_x) + int'(paddle_len) / 2) & 1023;
                    my[k] = (int'(paddle_y) - 5) & 1023;
                    mdx[k] = (k % 2 == 1) ? -1 : 1;
                    mdy[k] = -2;
                    mact[k] = 1;
                    mpend = 0;
                end
            end
        end
    endtask

    task automatic compare_all(input bit pulses);
        for (int k = 0; k < N; k++) begin
            chk($sformatf("active[%0d]", k), b_active[k], mact[k]);
            if (mact[k]) begin
                chk($sformatf("x[%0d]", k), b_xs[k*X_W +: X_W], mx[k]);
                chk($sformatf("y[%0d]", k), b_ys[k*Y_W +: Y_W], my[k]);
            end
        end
        chk("miss", miss, pulses ? mmiss : 1'b0);
        chk("hit_paddle", hit_paddle, pulses ? mhit : 1'b0);
    endtask

    task automatic pulse_launch();
        bit e;
        launch = 1'b1;
        do cycle(e); while (!e);
        launch = 1'b0;
    endtask

    task automatic settle();
        en_cycles(4);
        resolve_pend();
        compare_all(1'b0);
    endtask

    task automatic do_frame(input bit late_launch, output int lat);
        bit e;
        frame_tick = 1'b1;
        do cycle(e); while (!e);
        frame_tick = 1'b0;
        chk("busy_start", busy, 1);
        lat = 0;
        if (late_launch) begin
            pulse_launch();
            mpend = 1;
            lat = 1;
        end
        for (int c = 0; c < 400 && busy; c++) begin
            cycle(e);
            if (e) lat++;
        end
        chk("busy_end", busy, 0);
        model_frame();
        compare_all(1'b1);
    endtask

    vec_t vecs[4];

    initial begin
        int lat;
        bit e;
        bit seen;

        vecs[0] = '{px: 300, py: 460, len: 40, l_x: 320, l_y: 455, f_x: 321, f_y: 453};
        vecs[1] = '{px: 0,   py: 10,  len: 0,  l_x: 0,   l_y: 5,   f_x: 4,   f_y: 4};
        vecs[2] = '{px: 700, py: 200, len: 0,  l_x: 700, l_y: 195, f_x: 635, f_y: 193};
        vecs[3] = '{px: 100, py: 9,   len: 20, l_x: 110, l_y: 4,   f_x: 111, f_y: 4};

        do_reset();
        chk("rst_xs", b_xs, 0);
        chk("rst_ys", b_ys, 0);
        chk("rst_active", b_active, 0);
        chk("rst_busy", busy, 0);
        chk("rst_miss", miss, 0);
        chk("rst_hit", hit_paddle, 0);
        chk("rst_overrun", overrun, 0);

        // Table: launch position, one frame of motion, sweep latency
        for (int v = 0; v < 4; v++) begin
            do_reset();
            paddle_x = X_W'(vecs[v].px); paddle_y = Y_W'(vecs[v].py); paddle_len = 8'(vecs[v].len);
            pulse_launch();
            mpend = 1;
            settle();
            chk($sformatf("v%0d_launch_x", v), b_xs[X_W-1:0], vecs[v].l_x);
            chk($sformatf("v%0d_launch_y", v), b_ys[Y_W-1:0], vecs[v].l_y);
            chk($sformatf("v%0d_launch_act", v), b_active, 1);
            do_frame(1'b0, lat);
            chk($sformatf("v%0d_latency", v), lat, 2 * N + 1);
            chk($sformatf("v%0d_frame_x", v), b_xs[X_W-1:0], vecs[v].f_x);
            chk($sformatf("v%0d_frame_y", v), b_ys[Y_W-1:0], vecs[v].f_y);
            settle();
        end

        // Paddle hit with pulse held across disabled cycles, then miss and relaunch
        do_reset();
        paddle_x = 100; paddle_y = 10; paddle_len = 20;
        pulse_launch(); mpend = 1; settle();
        do_frame(1'b0, lat); settle();
        paddle_y = 12;
        do_frame(1'b0, lat); settle();
        do_frame(1'b0, lat);
        chk("hit_x", b_xs[X_W-1:0], 113);
        chk("hit_y", b_ys[Y_W-1:0], 7);
        chk("hit_pulse", hit_paddle, 1);
        enable = 1'b0;
        @(posedge clock); #1;
        @(posedge clock); #1;
        chk("hit_hold_disabled", hit_paddle, 1);
        cycle(e);
        chk("hit_pulse_end", hit_paddle, 0);
        settle();
        paddle_x = 500;
        seen = 0;
        for (int f = 0; f < 400 && !seen; f++) begin
            do_frame(1'b0, lat);
            seen = mmiss;
            if (!seen) settle();
        end
        chk("b0_lost", b_active[0], 0);
        chk("miss_pulse", miss, 1);
        en_cycles(2);
        chk("miss_pulse_end", miss, 0);
        pulse_launch(); mpend = 1; settle();
        chk("b0_relaunch", b_active[0], 1);

        // Reset in the middle of a sweep
        do_reset();
        paddle_x = 300; paddle_y = 460; paddle_len = 40;
        pulse_launch(); mpend = 1; settle();
        frame_tick = 1'b1; cycle(e); frame_tick = 1'b0;
        en_cycles(2);
        reset = 1'b0; enable = 1'b0;
        @(posedge clock); #1;
        reset = 1'b1;
        model_clear();
        chk("mid_rst_active", b_active, 0);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_xs", b_xs, 0);
        chk("mid_rst_ys", b_ys, 0);
        do_frame(1'b0, lat);
        chk("mid_rst_latency", lat, 2 * N + 1);
        settle();

        // Overrun: second frame_tick two cycles into a sweep
        do_reset();
        pulse_launch(); mpend = 1; settle();
        chk("overrun_clear", overrun, 0);
        frame_tick = 1'b1; cycle(e); frame_tick = 1'b0;
        en_cycles(1);
        frame_tick = 1'b1; cycle(e); frame_tick = 1'b0;
        chk("overrun_set", overrun, 1);
        for (int c = 0; c < 400 && busy; c++) cycle(e);
        chk("ovr_busy_end", busy, 0);
        model_frame();
        compare_all(1'b1);
        settle();
        chk("overrun_sticky", overrun, 1);
        chk("ovr_no_restart", busy, 0);

        // Three launches, fourth pends until a ball is lost
        do_reset();
        paddle_x = 300; paddle_y = 20; paddle_len = 40;
        for (int l = 0; l < 3; l++) begin
            pulse_launch(); mpend = 1; settle();
        end
        chk("full_mask", b_active, 3'b111);
        pulse_launch(); mpend = 1; settle();
        chk("pend_mask", b_active, 3'b111);
        paddle_x = 900;
        seen = 0;
        for (int f = 0; f < 400 && !seen; f++) begin
            do_frame(1'b0, lat);
            seen = mmiss;
            settle();
        end
        chk("relaunch_mask", b_active, 3'b001);

        // Randomized frames, launches and enable gating against the model
        rand_en = 1'b1;
        for (int it = 0; it < 250; it++) begin
            if ($urandom_range(3) == 0) begin
                paddle_x = X_W'($urandom_range(639));
                paddle_y = Y_W'($urandom_range(470, 300));
                paddle_len = 8'($urandom_range(255));
            end
            if ($urandom_range(3) == 0) begin
                pulse_launch(); mpend = 1; settle();
            end else begin
                do_frame($urandom_range(4) == 0, lat);
                settle();
            end
        end
        rand_en = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
